pwm_multi_channel: RTL and testbench

Parametrised multi-channel PWM peripheral; successor to the fixed 16-output, single-duty PWM block behind the SPI register file.
- One shared timebase: prescaler, programmable TOP, edge- or center-aligned counting.
- Per-channel duty cycle with shadow (pending) registers, loaded only at period boundaries, so the output is glitch-free.
- Per-channel output enable and PWM enable, same semantics as the previous generation.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_timebase.sv | 109 ++++++++++
 rtl/pwm_multi_channel.sv | 111 +++++++++++
 tb/tb_pwm_multi_channel.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Brief    : Shared types and default widths for the multi-channel PWM.
//  Revision : 1.0 - initial parametrised multi-channel release
// ============================================================================
package pwm_pkg;

    // Counting mode of the shared timebase
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_PRE_W = 8;

    // All-ones duty; truncated to the counter width where it is used
    localparam logic [31:0] DUTY_FULL = '1;

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_timebase
//  Brief    : Prescaler plus edge/center-aligned counter shared by all PWM
//             channels; flags the period boundary on the tick that ends it.
//  Revision : 1.0 - initial parametrised multi-channel release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             center_mode,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] top,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary
);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir_down;
    logic             r_started;
    pwm_mode_e        r_mode;

    pwm_mode_e        w_mode;
    logic             w_mode_chg;
    logic             w_tick;
    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_dir_down_nxt;

    assign w_mode     = pwm_mode_e'(center_mode);
    assign w_mode_chg = (w_mode != r_mode);
    // >= rather than == so a prescale lowered below the running count
    // still wraps at once instead of rolling through the full range
    assign w_tick     = enable && (r_pre >= prescale);

    // Counter/direction value that the next tick would load
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_dir_down_nxt = r_dir_down;
        if (w_mode == PWM_EDGE) begin
            w_dir_down_nxt = 1'b0;
            w_cnt_nxt      = (r_cnt >= top) ? '0 : r_cnt + 1'b1;
        end else if (top == '0) begin
            w_dir_down_nxt = 1'b0;
            w_cnt_nxt      = '0;
        end else if (!r_dir_down) begin
            // Turning point also catches a top lowered below the count
            if (r_cnt >= top) begin
                w_cnt_nxt      = r_cnt - 1'b1;
                w_dir_down_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else begin
            if (r_cnt == '0) begin
                w_cnt_nxt      = CNT_W'(1);
                w_dir_down_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    // A wrap into zero, or any tick while top is zero, closes a period;
    // the first tick after enable never does
    assign w_wrap   = ((w_cnt_nxt == '0) && (r_cnt != '0)) || (top == '0);
    assign boundary = enable && (w_mode_chg || (w_tick && r_started && w_wrap));
    assign cnt      = r_cnt;

    // Prescaler, counter, direction and mode tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre      <= '0;
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
            r_started  <= 1'b0;
            r_mode     <= w_mode;
        end else begin
            r_mode <= w_mode;
            if (!enable) begin
                r_pre      <= '0;
                r_cnt      <= '0;
                r_dir_down <= 1'b0;
                r_started  <= 1'b0;
            end else if (w_mode_chg) begin
                r_pre      <= '0;
                r_cnt      <= '0;
                r_dir_down <= 1'b0;
                r_started  <= 1'b1;
            end else if (w_tick) begin
                r_pre      <= '0;
                r_cnt      <= w_cnt_nxt;
                r_dir_down <= w_dir_down_nxt;
                r_started  <= 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_channel
//  Brief    : NUM_CH PWM outputs on one shared timebase, with shadowed duty
//             registers that only take effect at period boundaries.
//  Revision : 1.0 - initial parametrised multi-channel release
// ============================================================================
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NUM_CH   = 16,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PRE_W    = DEF_PRE_W,
    parameter int CH_IDX_W = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                center_mode,
    input  logic [PRE_W-1:0]    prescale,
    input  logic [CNT_W-1:0]    top,
    input  logic [NUM_CH-1:0]   en_out,
    input  logic [NUM_CH-1:0]   en_pwm,
    input  logic                duty_wr,
    input  logic [CH_IDX_W-1:0] duty_ch,
    input  logic [CNT_W-1:0]    duty_data,
    output logic [NUM_CH-1:0]   out,
    output logic                period_start
);

    localparam logic [CNT_W-1:0] c_DUTY_FULL = CNT_W'(DUTY_FULL);

    logic [CNT_W-1:0]  w_cnt;
    logic              w_boundary;
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_pwm;
    logic [NUM_CH-1:0] w_out_nxt;

    logic [CNT_W-1:0]  r_pending [NUM_CH];
    logic [CNT_W-1:0]  r_active  [NUM_CH];
    logic [NUM_CH-1:0] r_out;
    logic              r_period_start;

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .center_mode (center_mode),
        .prescale    (prescale),
        .top         (top),
        .cnt         (w_cnt),
        .boundary    (w_boundary)
    );

    // Per-channel write decode; indices at or beyond NUM_CH match nothing
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_hit[i] = duty_wr && (duty_ch == CH_IDX_W'(i));
        end
    end

    // Pending duties take writes any time; active copies refresh at a
    // boundary, with a same-cycle write bypassed straight in
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pending[i] <= '0;
                r_active[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_hit[i]) begin
                    r_pending[i] <= duty_data;
                end
                if (w_boundary) begin
                    r_active[i] <= w_wr_hit[i] ? duty_data : r_pending[i];
                end
            end
        end
    end

    // Duty compare and per-channel enable gating
    always_comb begin
        w_pwm     = '0;
        w_out_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pwm[i]     = (r_active[i] == c_DUTY_FULL) || (w_cnt < r_active[i]);
            w_out_nxt[i] = en_out[i] && (!en_pwm[i] || w_pwm[i]);
        end
    end

    // Registered outputs keep the pins glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_nxt;
            r_period_start <= w_boundary;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_multi_channel
//  Brief    : Directed scoreboard bench for pwm_multi_channel (6 channels so
//             an out-of-range channel index is representable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_channel;

    localparam int NUM_CH   = 6;
    localparam int CNT_W    = 8;
    localparam int PRE_W    = 8;
    localparam int CH_IDX_W = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                center_mode;
    logic [PRE_W-1:0]    prescale;
    logic [CNT_W-1:0]    top;
    logic [NUM_CH-1:0]   en_out;
    logic [NUM_CH-1:0]   en_pwm;
    logic                duty_wr;
    logic [CH_IDX_W-1:0] duty_ch;
    logic [CNT_W-1:0]    duty_data;
    logic [NUM_CH-1:0]   pwm_out;
    logic                period_start;

    pwm_multi_channel #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .PRE_W    (PRE_W),
        .CH_IDX_W (CH_IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .center_mode  (center_mode),
        .prescale     (prescale),
        .top          (top),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty_wr      (duty_wr),
        .duty_ch      (duty_ch),
        .duty_data    (duty_data),
        .out          (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] out;
        logic              ps;
        string             tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push_exp(input int c, input logic [NUM_CH-1:0] o,
                            input logic p, input string tag);
        exp_t e;
        e.cyc = c;
        e.out = o;
        e.ps  = p;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation stamped for the current cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s: vector for cycle %0d not checked (now %0d)",
                             e.tag, e.cyc, cyc);
                end else if (pwm_out !== e.out || period_start !== e.ps) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: out=%b period_start=%b, expected out=%b period_start=%b",
                             e.tag, cyc, pwm_out, period_start, e.out, e.ps);
                end
            end
        end
    end

    task automatic goto(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic write_duty(input logic [CH_IDX_W-1:0] ch, input logic [CNT_W-1:0] d);
        duty_wr   = 1'b1;
        duty_ch   = ch;
        duty_data = d;
        @(negedge clk);
        duty_wr   = 1'b0;
    endtask

    // Stimulus: every expectation is pushed before its cycle arrives
    initial begin
        int c, p, d, t, k, base, r;
        logic [NUM_CH-1:0] o;

        rst         = 1'b1;
        enable      = 1'b0;
        center_mode = 1'b0;
        prescale    = '0;
        top         = 8'd9;
        en_out      = 6'b101111;   // ch4 output disabled
        en_pwm      = 6'b110111;   // ch3 static high
        duty_wr     = 1'b0;
        duty_ch     = '0;
        duty_data   = '0;

        push_exp(2, '0, 1'b0, "reset_init");
        goto(3);
        rst = 1'b0;

        // Duty writes while stopped only land in pending
        write_duty(3'd0, 8'd3);
        write_duty(3'd1, 8'd0);
        write_duty(3'd2, 8'hFF);
        write_duty(3'd3, 8'd5);
        write_duty(3'd4, 8'd5);
        write_duty(3'd5, 8'd0);
        write_duty(3'd6, 8'hFF);   // out of range, must be dropped
        push_exp(cyc + 2, 6'b001000, 1'b0, "idle_static");
        push_exp(cyc + 3, 6'b001000, 1'b0, "idle_static");
        goto(cyc + 4);

        // Edge mode, prescale 0, top 9: boundaries every 10 edges from enable
        base   = cyc;
        enable = 1'b1;
        for (int j = 1; j <= 80; j++) begin
            c = (j - 1) % 10;
            p = (j - 1) / 10;
            d = (p == 0) ? 0 : (p <= 4) ? 3 : (p == 5) ? 7 : 5;
            o = 6'b001000;
            o[0] = (c < d);
            o[2] = (p != 0);
            push_exp(base + j, o, (j % 10) == 0, "edge_shadow");
        end
        goto(base + 44);
        write_duty(3'd0, 8'd7);    // mid-period: next period only
        goto(base + 54);
        write_duty(3'd6, 8'hFF);   // out of range, must be dropped
        goto(base + 59);
        write_duty(3'd0, 8'd5);    // lands on the boundary edge: bypass

        // Two-cycle reset mid-run with a duty write that must be lost
        goto(base + 80);
        r = base + 82;
        push_exp(r - 1, '0, 1'b0, "reset_mid");
        push_exp(r,     '0, 1'b0, "reset_mid");
        for (int j = 1; j <= 30; j++) begin
            push_exp(r + j, 6'b001000, (j % 10) == 0, "post_reset");
        end
        rst       = 1'b1;
        duty_wr   = 1'b1;
        duty_ch   = 3'd1;
        duty_data = 8'hFF;
        goto(r);
        rst     = 1'b0;
        duty_wr = 1'b0;
        goto(r + 25);
        write_duty(3'd0, 8'd2);
        write_duty(3'd2, 8'hFF);

        // Top lowered 9 -> 2 while cnt is 6: wrap on the next tick
        base = r + 30;
        for (int j = 1; j <= 16; j++) begin
            if (j <= 7) begin
                c = j - 1;
            end else begin
                c = (j - 8) % 3;
            end
            o = 6'b001100;
            o[0] = (c < 2);
            push_exp(base + j, o, (j >= 7) && ((j - 7) % 3 == 0), "top_lower");
        end
        goto(base + 6);
        top = 8'd2;

        // enable low: counter frozen at 0, outputs show compare at cnt 0
        goto(base + 16);
        base   = cyc;
        enable = 1'b0;
        for (int j = 2; j <= 12; j++) begin
            push_exp(base + j, 6'b001101, 1'b0, "disabled");
        end
        goto(base + 10);
        center_mode = 1'b1;
        top         = 8'd4;
        prescale    = 8'd1;

        // Center mode, prescale 1, top 4, ch0 duty 2: 16-clk period
        goto(base + 12);
        base   = cyc;
        enable = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            k = (j - 1) % 16;
            t = k / 2;
            c = (t <= 4) ? t : 8 - t;
            o = 6'b001100;
            o[0] = (c < 2);
            push_exp(base + j, o, (j % 16) == 0, "center");
        end
        goto(base + 34);

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
